rotfpga2b_cfg_loader: RTL and testbench
=======================================

Name: rotfpga2b_cfg_loader

Overview:
- Sequences configuration of the rotfpga2b grid over its scan chain.
- Accepts a configuration bitstream as bytes from a host over a valid/ready stream and generates the grid clock, scan enable and scan-in.
- Captures the grid's scan-out into a readback byte stream, so the old configuration is returned while the new one is loaded.
- Sits between the host/wishbone-side register block and the grid's in_se, in_sc, clock and reset pins.

Parameters:
- CHAIN_LEN, 64: scan chain length in bits; must be at least 1.
- DIV, 1: system clocks per grid-clock half period; must be at least 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy=1.
- abort  in  1  one-cycle pulse that terminates a load; ignored when idle.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when all CHAIN_LEN bits have been shifted and the last readback byte is accepted.
- in_data  in  8  configuration byte, LSB shifted first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_data  out  8  readback byte, first-captured bit in the LSB.
- out_valid  out  1  out_data is valid; held with stable data until out_ready.
- out_ready  in  1  host accepts readback.
- g_clk  out  1  grid clock, driving the grid's in[0].
- g_rst_n  out  1  grid reset, active low.
- g_se  out  1  grid scan enable.
- g_sc  out  1  grid scan-in.
- g_sc_out  in  1  grid scan-out.

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, g_clk=0, g_rst_n=0, g_se=0, g_sc=0. Internal bit counter=0, state=IDLE.
- g_rst_n is 0 during rst and while busy=1, and 1 otherwise. The grid therefore runs only when it is idle.
- IDLE:
  - g_clk=0, g_se=0.
  - On start, go to FETCH; busy is set.
- FETCH:
  - in_ready=1 until a byte is taken.
  - On the handshake, latch the byte into the shift register and go to LO. in_ready drops the next cycle.
- LO:
  - g_se=1, g_clk=0, g_sc = shift-register LSB.
  - Stay DIV cycles, then go to HI.
- HI:
  - g_clk=1 for DIV cycles.
  - On the cycle g_clk rises, sample g_sc_out into readback bit position (bit count mod 8), shift the input register right, and increment the bit counter.
  - At the end of HI:
    - if the counter equals CHAIN_LEN, or 8 bits of the current byte have been used, go to EMIT;
    - otherwise go to LO.
- EMIT:
  - g_clk=0, out_valid=1.
  - On the out_ready handshake:
    - if the counter equals CHAIN_LEN, go to FIN;
    - otherwise go to FETCH.
  - The grid clock is held low under backpressure; no bits are lost.
- FIN:
  - g_se=0, done=1 for one cycle, busy=0, then go to IDLE.
- Final byte when CHAIN_LEN mod 8 != 0:
  - Only the low (CHAIN_LEN mod 8) input bits are shifted.
  - The remaining upper input bits are discarded.
  - The corresponding readback MSBs are 0.
- Byte count: total input bytes = total output bytes = ceil(CHAIN_LEN/8).
- Latency: each bit takes 2*DIV clocks. Stalls on in_valid=0 (in FETCH) or out_ready=0 (in EMIT) extend time only; they never corrupt the bit order.
- abort in any non-IDLE state:
  - Next cycle: state=IDLE, g_clk=0, g_se=0, out_valid=0, in_ready=0, busy=0.
  - done is not pulsed; the counter is cleared.
  - A pending readback byte is dropped.
  - The grid keeps a partially shifted chain, which is the host's responsibility.
- start and abort in the same cycle while idle: start wins, since abort is ignored when idle.
- start while busy: ignored.
- rst mid-load: asynchronous return to reset values; the grid is held in reset from that point on.
- The bit counter is wide enough for CHAIN_LEN, i.e. $clog2(CHAIN_LEN+1) bits.

Test Plan:
- CHAIN_LEN=12, DIV=1.
  - Stimulus: start; bytes 0xA5 then 0x03, in_valid held high; out_ready=1; g_sc_out tied to a 12-bit model chain preloaded with 0x5C3.
  - Required response: g_sc sequence 1,0,1,0,0,1,0,1,1,1,0,0; readback bytes 0xC3 then 0x05; done pulses once; 24 g_clk-active cycles in total.
- Backpressure:
  - Stimulus: as above, with out_ready low for 10 cycles at the first EMIT.
  - Required response: g_clk stays 0 and out_data stays stable throughout; final results are identical.
- Input starvation:
  - Stimulus: in_valid delayed 7 cycles before the second byte.
  - Required response: in_ready stays high, g_se stays 1, g_clk stays 0; output bytes are unchanged.
- Abort:
  - Stimulus: abort after 5 bits.
  - Required response: busy=0 next cycle, g_se=0, no done, no out_valid. A subsequent start runs a full 12-bit load correctly.
- DIV=3, CHAIN_LEN=8:
  - Stimulus: one byte.
  - Required response: each g_clk phase is 3 cycles long; g_rst_n is 0 throughout busy and 1 after done.
- Asynchronous reset:
  - Stimulus: rst asserted mid-HI.
  - Required response: g_clk=0 and g_rst_n=0 immediately, without waiting for a clock edge; all outputs take their reset values.

Source files
------------

// File: rtl/rotfpga2b_cfg_loader.sv
// Scan-chain configuration loader for the rotfpga2b grid: shifts host bytes
// into the grid scan chain while returning the old chain contents as bytes.
module rotfpga2b_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned DIV       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       g_clk,
  output logic       g_rst_n,
  output logic       g_se,
  output logic       g_sc,
  input  logic       g_sc_out
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       sr;
  logic             phase_end_c;
  logic             last_bit_c;
  logic             take_c;
  logic             rise_c;
  logic             busy_nxt_c;

  // Next-state decode; abort overrides everything except IDLE.
  always_comb begin
    state_nxt   = state;
    take_c      = 1'b0;
    rise_c      = 1'b0;
    phase_end_c = (div_cnt == DIV_W'(DIV - 1));
    last_bit_c  = (bit_cnt == CNT_W'(CHAIN_LEN));
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (in_valid) begin
                 state_nxt = S_LO;
                 take_c    = 1'b1;
               end
      S_LO:    if (phase_end_c) begin
                 state_nxt = S_HI;
                 rise_c    = 1'b1;
               end
      S_HI:    if (phase_end_c)
                 state_nxt = (last_bit_c || bit_idx == 3'd0) ? S_EMIT : S_LO;
      S_EMIT:  if (out_ready) state_nxt = last_bit_c ? S_FIN : S_FETCH;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      take_c    = 1'b0;
      rise_c    = 1'b0;
    end
    busy_nxt_c = (state_nxt == S_FETCH) || (state_nxt == S_LO) ||
                 (state_nxt == S_HI) || (state_nxt == S_EMIT);
  end

  // State, datapath and registered outputs (outputs follow the next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      div_cnt   <= '0;
      sr        <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      g_clk     <= 1'b0;
      g_rst_n   <= 1'b0;
      g_se      <= 1'b0;
      g_sc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= (state_nxt != state) ? '0 : div_cnt + DIV_W'(1);

      if (state_nxt == S_IDLE) begin
        bit_cnt <= '0;
        bit_idx <= 3'd0;
      end else if (rise_c) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        bit_idx <= bit_idx + 3'd1;
      end

      // Byte latch on fetch; capture scan-out and shift on the g_clk rise.
      if (take_c) begin
        sr       <= in_data;
        out_data <= 8'd0;
      end else if (rise_c) begin
        sr                <= {1'b0, sr[7:1]};
        out_data[bit_idx] <= g_sc_out;
      end

      // Scan-in changes only when entering LO so it is stable across HI.
      if (take_c)
        g_sc <= in_data[0];
      else if (state == S_HI && state_nxt == S_LO)
        g_sc <= sr[0];
      else if (!busy_nxt_c)
        g_sc <= 1'b0;

      busy      <= busy_nxt_c;
      done      <= (state_nxt == S_FIN);
      in_ready  <= (state_nxt == S_FETCH);
      out_valid <= (state_nxt == S_EMIT);
      g_clk     <= (state_nxt == S_HI);
      g_se      <= busy_nxt_c;
      g_rst_n   <= !busy_nxt_c;
    end
  end

endmodule

// File: tb/tb_rotfpga2b_cfg_loader.sv
// Directed bench for rotfpga2b_cfg_loader: a 12-bit/DIV=1 instance and an
// 8-bit/DIV=3 instance, each feeding a small behavioural scan-chain model.
module tb_rotfpga2b_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CHAIN_LEN=12, DIV=1
  logic       rst_a = 1'b0;
  logic       a_start = 1'b0, a_abort = 1'b0;
  logic       a_busy, a_done;
  logic [7:0] a_in_data = 8'd0;
  logic       a_in_valid = 1'b0, a_in_ready;
  logic [7:0] a_out_data;
  logic       a_out_valid, a_out_ready = 1'b0;
  logic       a_g_clk, a_g_rst_n, a_g_se, a_g_sc, a_g_sc_out;

  // Instance B: CHAIN_LEN=8, DIV=3
  logic       rst_b = 1'b0;
  logic       b_start = 1'b0, b_abort = 1'b0;
  logic       b_busy, b_done;
  logic [7:0] b_in_data = 8'd0;
  logic       b_in_valid = 1'b0, b_in_ready;
  logic [7:0] b_out_data;
  logic       b_out_valid, b_out_ready = 1'b0;
  logic       b_g_clk, b_g_rst_n, b_g_se, b_g_sc, b_g_sc_out;

  rotfpga2b_cfg_loader #(.CHAIN_LEN(12), .DIV(1)) u_a (
    .clk(clk), .rst(rst_a), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .g_clk(a_g_clk), .g_rst_n(a_g_rst_n), .g_se(a_g_se), .g_sc(a_g_sc),
    .g_sc_out(a_g_sc_out)
  );

  rotfpga2b_cfg_loader #(.CHAIN_LEN(8), .DIV(3)) u_b (
    .clk(clk), .rst(rst_b), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .g_clk(b_g_clk), .g_rst_n(b_g_rst_n), .g_se(b_g_se), .g_sc(b_g_sc),
    .g_sc_out(b_g_sc_out)
  );

  int passed = 0;
  int total  = 0;

  // Grid scan-chain models: scan-out is bit 0, scan-in enters at the MSB.
  logic [11:0] chain_a = 12'd0;
  logic [7:0]  chain_b = 8'd0;
  logic        sc_log[$];
  logic [7:0]  rb_a[$];
  assign a_g_sc_out = chain_a[0];
  assign b_g_sc_out = chain_b[0];

  always @(posedge a_g_clk) begin
    if (a_g_se) begin
      sc_log.push_back(a_g_sc);
      chain_a = {a_g_sc, chain_a[11:1]};
    end
  end

  always @(posedge b_g_clk) begin
    if (b_g_se) chain_b = {b_g_sc, chain_b[7:1]};
  end

  // Observation counters for instance A.
  int act_a = 0, done_a = 0, rstn_bad_a = 0;
  int stall_bad = 0, starve_bad = 0;
  logic a_timeout = 1'b0;

  always @(negedge clk) begin
    if (a_g_se && !a_in_ready && !a_out_valid) act_a++;
    if (a_done) done_a++;
    if (a_busy && a_g_rst_n) rstn_bad_a++;
  end

  // Full 12-bit load on instance A with optional readback stall / input starvation.
  task automatic run_a(input int stall, input int starve);
    int idx, starve_left, stall_left;
    logic pend_in;
    logic [7:0] held;
    sc_log.delete(); rb_a.delete();
    act_a = 0; done_a = 0; rstn_bad_a = 0; stall_bad = 0; starve_bad = 0;
    a_timeout = 1'b1; held = 8'd0;
    chain_a = 12'h5C3;
    idx = 0; starve_left = starve; stall_left = stall; pend_in = 1'b0;
    a_in_data = 8'hA5; a_in_valid = 1'b1; a_out_ready = (stall == 0);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (a_done) begin a_timeout = 1'b0; break; end
      if (pend_in) begin
        idx++;
        if (idx == 1) begin
          a_in_data = 8'h03;
          if (starve > 0) a_in_valid = 1'b0;
        end else a_in_valid = 1'b0;
      end else if (idx == 1 && a_in_ready && !a_in_valid && starve_left > 0) begin
        if (a_g_se !== 1'b1 || a_g_clk !== 1'b0) starve_bad++;
        starve_left--;
        if (starve_left == 0) a_in_valid = 1'b1;
      end
      if (a_out_valid && !a_out_ready && stall_left > 0) begin
        if (stall_left == stall) held = a_out_data;
        if (a_g_clk !== 1'b0 || a_out_data !== held) stall_bad++;
        stall_left--;
        if (stall_left == 0) a_out_ready = 1'b1;
      end
      pend_in = a_in_valid && a_in_ready;
      if (a_out_valid && a_out_ready) rb_a.push_back(a_out_data);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_a = 1'b1; rst_b = 1'b1;
    #1;
    total++; if (a_busy !== 1'b0)     $display("FAIL reset_busy got %b want 0", a_busy);      else passed++;
    total++; if (a_done !== 1'b0)     $display("FAIL reset_done got %b want 0", a_done);      else passed++;
    total++; if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", a_in_ready); else passed++;
    total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else passed++;
    total++; if (a_out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", a_out_data); else passed++;
    total++; if ({a_g_clk, a_g_rst_n, a_g_se, a_g_sc} !== 4'b0000)
      $display("FAIL reset_grid_pins got %b want 0000", {a_g_clk, a_g_rst_n, a_g_se, a_g_sc}); else passed++;
    total++; if ({b_busy, b_g_clk, b_g_rst_n, b_g_se} !== 4'b0000)
      $display("FAIL reset_b_pins got %b want 0000", {b_busy, b_g_clk, b_g_rst_n, b_g_se}); else passed++;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    total++; if ({a_g_rst_n, b_g_rst_n} !== 2'b11)
      $display("FAIL idle_g_rst_n got %b want 11", {a_g_rst_n, b_g_rst_n}); else passed++;
  endtask

  task automatic check_a_results(input string tag);
    logic exp_sc[12];
    logic got_sc[12];
    exp_sc = '{1,0,1,0,0,1,0,1,1,1,0,0};
    for (int i = 0; i < 12; i++) got_sc[i] = (i < sc_log.size()) ? sc_log[i] : 1'bx;
    total++; if (a_timeout !== 1'b0) $display("FAIL %s_timeout no done within bound", tag); else passed++;
    total++; if (sc_log.size() != 12 || got_sc != exp_sc)
      $display("FAIL %s_sc_seq got %0d bits want 12 bits 101001011100", tag, sc_log.size()); else passed++;
    total++; if (rb_a.size() != 2 || rb_a[0] !== 8'hC3 || rb_a[1] !== 8'h05)
      $display("FAIL %s_readback got n=%0d want C3 05", tag, rb_a.size()); else passed++;
    total++; if (done_a != 1) $display("FAIL %s_done_pulses got %0d want 1", tag, done_a); else passed++;
    total++; if (act_a != 24) $display("FAIL %s_active_cycles got %0d want 24", tag, act_a); else passed++;
    total++; if (chain_a !== 12'h3A5) $display("FAIL %s_chain got %h want 3a5", tag, chain_a); else passed++;
    total++; if (rstn_bad_a != 0) $display("FAIL %s_g_rst_n_busy got %0d want 0", tag, rstn_bad_a); else passed++;
  endtask

  task automatic test_basic_load;
    run_a(0, 0);
    check_a_results("basic");
  endtask

  task automatic test_backpressure;
    run_a(10, 0);
    check_a_results("bp");
    total++; if (stall_bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", stall_bad); else passed++;
  endtask

  task automatic test_starvation;
    run_a(0, 7);
    check_a_results("starve");
    total++; if (starve_bad != 0) $display("FAIL starve_hold got %0d bad cycles want 0", starve_bad); else passed++;
  endtask

  task automatic test_abort;
    int ov;
    logic reached;
    sc_log.delete(); done_a = 0; ov = 0; reached = 1'b0;
    chain_a = 12'h5C3;
    a_in_data = 8'hA5; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk); a_start = 1'b1; a_abort = 1'b1;
    @(negedge clk); a_start = 1'b0; a_abort = 1'b0;
    total++; if (a_busy !== 1'b1) $display("FAIL start_abort_idle busy got %b want 1", a_busy); else passed++;
    for (int c = 0; c < 100; c++) begin
      if (sc_log.size() >= 5) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (reached !== 1'b1) $display("FAIL abort_reach5 got %0d bits want 5", sc_log.size()); else passed++;
    a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0; a_in_valid = 1'b0;
    total++; if ({a_busy, a_g_se, a_g_clk, a_out_valid, a_in_ready} !== 5'b00000)
      $display("FAIL abort_next got %b want 00000", {a_busy, a_g_se, a_g_clk, a_out_valid, a_in_ready}); else passed++;
    for (int c = 0; c < 20; c++) begin
      if (a_out_valid) ov++;
      @(negedge clk);
    end
    total++; if (done_a != 0 || ov != 0 || sc_log.size() != 5)
      $display("FAIL abort_quiet got done=%0d ov=%0d bits=%0d want 0 0 5", done_a, ov, sc_log.size()); else passed++;
    run_a(0, 0);
    check_a_results("post_abort");
  endtask

  task automatic test_div3;
    int act, hi, run, bad, rst_bad;
    logic prev, finished;
    logic [7:0] rb;
    act = 0; hi = 0; run = 0; bad = 0; rst_bad = 0; prev = 1'b0; finished = 1'b0; rb = 8'hxx;
    chain_b = 8'h96;
    b_in_data = 8'h3C; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (b_done) begin finished = 1'b1; break; end
      if (b_busy && b_g_rst_n !== 1'b0) rst_bad++;
      if (b_g_se && !b_in_ready && !b_out_valid) begin
        act++;
        if (b_g_clk) hi++;
        if (run > 0 && b_g_clk == prev) run++;
        else begin
          if (run > 0 && run != 3) bad++;
          run = 1; prev = b_g_clk;
        end
      end
      if (b_in_ready && b_in_valid) begin
        @(negedge clk); b_in_valid = 1'b0; continue;
      end
      if (b_out_valid && b_out_ready) rb = b_out_data;
      @(negedge clk);
    end
    if (run != 3) bad++;
    total++; if (finished !== 1'b1) $display("FAIL div3_timeout no done within bound"); else passed++;
    total++; if (act != 48 || hi != 24) $display("FAIL div3_cycles got act=%0d hi=%0d want 48 24", act, hi); else passed++;
    total++; if (bad != 0) $display("FAIL div3_phase_len got %0d bad phases want 0", bad); else passed++;
    total++; if (rb !== 8'h96) $display("FAIL div3_readback got %h want 96", rb); else passed++;
    total++; if (chain_b !== 8'h3C) $display("FAIL div3_chain got %h want 3c", chain_b); else passed++;
    total++; if (rst_bad != 0) $display("FAIL div3_g_rst_n_busy got %0d want 0", rst_bad); else passed++;
    @(negedge clk);
    total++; if ({b_busy, b_g_rst_n} !== 2'b01) $display("FAIL div3_after_done got %b want 01", {b_busy, b_g_rst_n}); else passed++;
    b_out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    logic reached;
    reached = 1'b0;
    chain_a = 12'h5C3;
    a_in_data = 8'hA5; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (a_g_clk) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (reached !== 1'b1) $display("FAIL arst_reach_hi got %b want 1", a_g_clk); else passed++;
    #2 rst_a = 1'b1;
    #1;
    total++; if ({a_g_clk, a_g_rst_n, a_g_se, a_g_sc} !== 4'b0000)
      $display("FAIL arst_grid got %b want 0000", {a_g_clk, a_g_rst_n, a_g_se, a_g_sc}); else passed++;
    total++; if ({a_busy, a_done, a_in_ready, a_out_valid} !== 4'b0000 || a_out_data !== 8'h00)
      $display("FAIL arst_ctrl got %b data %h want 0000 00", {a_busy, a_done, a_in_ready, a_out_valid}, a_out_data); else passed++;
    repeat (2) @(negedge clk);
    total++; if (a_g_rst_n !== 1'b0) $display("FAIL arst_held got %b want 0", a_g_rst_n); else passed++;
    rst_a = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    total++; if ({a_busy, a_g_rst_n} !== 2'b01) $display("FAIL arst_release got %b want 01", {a_busy, a_g_rst_n}); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_starvation();
    test_abort();
    test_div3();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
